// File: rtl/adcmem_frame_reader.sv
// Read-side frame engine for the 512x16 ADC sample memory: streams N words from a start address.
// Optional header word per frame when ADCMEM_RD_HDR_EN is defined.
module adcmem_frame_reader #(
    parameter int          ADDR_W  = 9,
    parameter int          DATA_W  = 16,
    parameter int          LEN_W   = 10,
    parameter logic [7:0]  HDR_TAG = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              port0_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              len_err
);

`ifdef ADCMEM_RD_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam int             DEPTH_I = 1 << ADDR_W;
    localparam logic [LEN_W:0] DEPTH   = DEPTH_I[LEN_W:0];

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_FETCH, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [7:0]          seq_q, seq_d;
    logic                len_err_q, len_err_d;

    logic                len_ok, load_ok, accept, fetch, hdr_load;
    logic [DATA_W-1:0]   hdr_word;

    assign len_ok   = (frame_len != '0) && ({1'b0, frame_len} <= DEPTH);
    assign load_ok  = !out_valid_q || out_ready;
    assign accept   = out_valid_q && out_ready;
    // Port 0 owns the shared read data whenever it reads, so the reader must not load then.
    assign fetch    = (state_q == S_FETCH) && load_ok && !port0_re && (rem_q != '0);
    assign hdr_load = HDR_EN && (state_q == S_HDR) && load_ok;
    assign hdr_word = DATA_W'({HDR_TAG, seq_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            seq_q       <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            seq_q       <= seq_d;
            len_err_q   <= len_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && len_ok) state_d = HDR_EN ? S_HDR : S_FETCH;
            S_HDR:   if (load_ok) state_d = S_FETCH;
            S_FETCH: if (accept && out_last_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        seq_d       = seq_q;
        len_err_d   = 1'b0;

        if (state_q == S_IDLE && start) begin
            if (len_ok) begin
                ptr_d = base_addr;
                rem_d = frame_len;
            end else begin
                len_err_d = 1'b1;
            end
        end

        if (accept)
            out_valid_d = 1'b0;

        if (hdr_load) begin
            out_data_d  = hdr_word;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
        end

        if (fetch) begin
            out_data_d  = mem_dout;
            out_valid_d = 1'b1;
            out_last_d  = (rem_q == LEN_W'(1));
            ptr_d       = ptr_q + 1'b1;
            rem_d       = rem_q - 1'b1;
        end

        if (state_q == S_DONE)
            seq_d = seq_q + 8'd1;
    end

    always_comb begin
        mem_re    = fetch;
        mem_addr  = ptr_q;
        out_data  = out_data_q;
        out_valid = out_valid_q;
        out_last  = out_last_q;
        busy      = (state_q == S_HDR) || (state_q == S_FETCH);
        done      = (state_q == S_DONE);
        len_err   = len_err_q;
    end

endmodule

// File: tb/tb_adcmem_frame_reader.sv
// Directed bench for adcmem_frame_reader (default build, no header word).
module tb_adcmem_frame_reader;

    logic        clk = 1'b0;
    logic        rst, start, port0_re, out_ready;
    logic [8:0]  base_addr, mem_addr;
    logic [9:0]  frame_len;
    logic        mem_re, out_valid, out_last, busy, done, len_err;
    logic [15:0] mem_dout, out_data;

    logic [15:0] mem [512];
    logic [8:0]  p0_addr = 9'd100;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0]  aq[$];
    logic [15:0] dq[$];
    logic        lq[$];
    int          first_v, hold_err, got_done;
    logic        done_busy;

    adcmem_frame_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .frame_len(frame_len),
        .port0_re(port0_re), .mem_addr(mem_addr), .mem_re(mem_re), .mem_dout(mem_dout),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    // Shared read data: port 0 wins whenever it reads.
    assign mem_dout = port0_re ? mem[p0_addr] : mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [8:0] b, input logic [9:0] l);
        start = 1'b1; base_addr = b; frame_len = l;
        tick();
        start = 1'b0;
    endtask

    // Runs the frame cycle by cycle; bit i of each mask applies at cycle i after the start edge.
    task automatic collect(input logic [31:0] nr, input logic [31:0] p0, input logic [31:0] st,
                           input int maxc);
        logic        pv = 1'b0;
        logic [15:0] pd = '0;
        logic        pl = 1'b0;
        aq.delete(); dq.delete(); lq.delete();
        first_v = -1; hold_err = 0; got_done = 0; done_busy = 1'b1;
        for (int i = 0; i < maxc && got_done == 0; i++) begin
            out_ready = !nr[i % 32];
            port0_re  = p0[i % 32];
            start     = st[i % 32];
            #1;
            if (pv && !(out_valid && out_data == pd && out_last == pl)) hold_err++;
            pv = out_valid && !out_ready; pd = out_data; pl = out_last;
            if (mem_re) aq.push_back(mem_addr);
            if (out_valid && first_v < 0) first_v = i;
            if (out_valid && out_ready) begin
                dq.push_back(out_data);
                lq.push_back(out_last);
            end
            if (done) begin
                got_done  = 1;
                done_busy = busy;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        out_ready = 1'b1; port0_re = 1'b0; start = 1'b0;
        chk("done_seen", got_done, 1);
        chk("busy_at_done", done_busy, 1'b0);
        chk("done_1cyc", done, 1'b0);
    endtask

    task automatic check4(input string tag, input logic [15:0] ed [4], input logic [8:0] ea [4]);
        int nl = 0;
        chk({tag, "_nwords"}, dq.size(), 4);
        chk({tag, "_nreads"}, aq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < dq.size()) chk($sformatf("%s_data%0d", tag, k), dq[k], ed[k]);
            if (k < aq.size()) chk($sformatf("%s_addr%0d", tag, k), aq[k], ea[k]);
        end
        foreach (lq[k]) nl += int'(lq[k]);
        chk({tag, "_nlast"}, nl, 1);
        if (lq.size() == 4) chk({tag, "_last_pos"}, lq[3], 1'b1);
        chk({tag, "_hold"}, hold_err, 0);
    endtask

    initial begin
        logic [15:0] ed [4];
        logic [8:0]  ea [4];
        int          seen;

        rst = 1'b1; start = 1'b0; base_addr = '0; frame_len = '0;
        port0_re = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0;
        mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
        mem[100] = 16'hDEAD; mem[200] = 16'h0BAD;
        tick(); tick();
        chk("rst_mem_re", mem_re, 1'b0);
        chk("rst_mem_addr", mem_addr, 9'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'd0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        rst = 1'b0;
        tick();

        // Basic frame, always ready
        ea = '{9'd0, 9'd1, 9'd2, 9'd3};
        ed = '{16'd1, 16'd2, 16'd3, 16'd4};
        start_frame(9'd0, 10'd4);
        chk("basic_busy", busy, 1'b1);
        collect(32'h0, 32'h0, 32'h0, 40);
        check4("basic", ed, ea);
        chk("basic_latency", first_v, 1);

        // Downstream stall of 3 cycles right after the first word
        start_frame(9'd0, 10'd4);
        collect(32'hE, 32'h0, 32'h0, 40);
        check4("stall", ed, ea);

        // Port 0 steals the read data for 2 cycles
        start_frame(9'd0, 10'd4);
        collect(32'h0, 32'h6, 32'h0, 40);
        check4("p0", ed, ea);

        // Start while busy and start in the DONE cycle are both ignored
        start_frame(9'd0, 10'd4);
        base_addr = 9'd200; frame_len = 10'd2;
        collect(32'h0, 32'h0, 32'h24, 40);
        check4("ign", ed, ea);
        chk("ign_idle_busy", busy, 1'b0);

        // Reset mid-frame abandons it without a done pulse
        start_frame(9'd0, 10'd4);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_mem_re", mem_re, 1'b0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy || out_valid) seen++;
            tick();
        end
        chk("mrst_quiet", seen, 0);

        // Address wrap at the top of memory
        mem[510] = 16'h0AAA; mem[511] = 16'h0BBB; mem[0] = 16'h0CCC; mem[1] = 16'h0DDD;
        ea = '{9'd510, 9'd511, 9'd0, 9'd1};
        ed = '{16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD};
        start_frame(9'd510, 10'd4);
        collect(32'h0, 32'h0, 32'h0, 40);
        check4("wrap", ed, ea);

        // Illegal lengths
        start = 1'b1; frame_len = 10'd0; base_addr = 9'd0;
        tick();
        start = 1'b0;
        chk("len0_err", len_err, 1'b1);
        chk("len0_busy", busy, 1'b0);
        tick();
        chk("len0_err_pulse", len_err, 1'b0);
        start = 1'b1; frame_len = 10'd513;
        tick();
        start = 1'b0;
        chk("len513_err", len_err, 1'b1);
        chk("len513_busy", busy, 1'b0);
        tick();

        // Whole-memory frame from base 5 ends at address 4
        for (int i = 0; i < 512; i++) mem[i] = 16'h8000 | 16'(i);
        start_frame(9'd5, 10'd512);
        chk("full_len_err", len_err, 1'b0);
        chk("full_busy", busy, 1'b1);
        collect(32'h0, 32'h0, 32'h0, 600);
        chk("full_nwords", dq.size(), 512);
        chk("full_nreads", aq.size(), 512);
        if (dq.size() == 512) begin
            chk("full_first", dq[0], 16'h8005);
            chk("full_top", dq[506], 16'h81FF);
            chk("full_wrap", dq[507], 16'h8000);
            chk("full_lastword", dq[511], 16'h8004);
            chk("full_lastaddr", aq[511], 9'd4);
            chk("full_lastflag", lq[511], 1'b1);
            chk("full_notlast", lq[510], 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
